// File: rtl/ft64_btb_pkg.sv
// Shared types and constants for the FT64 BTB write-side updater.
package ft64_btb_pkg;
   localparam int          BTB_AMSB  = 31;
   localparam int          BTB_IDXW  = 10;
   localparam logic [31:0] BTB_RSTPC = 32'hFFFC0100;

   typedef struct packed {
      logic              valid;
      logic [BTB_AMSB:0] pc;
      logic [BTB_AMSB:0] tgt;
   } btb_ent_t;

   typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} upd_state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction
endpackage

// File: rtl/ft64_btb_updq.sv
// Update queue: QDEP-entry FIFO, two ordered push ports, one pop port.
// Pushes beyond the free room (after a same-cycle pop) are reported in o_drop.
module ft64_btb_updq
   import ft64_btb_pkg::*;
#(
   parameter int QDEP = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push0,
   input  btb_ent_t              i_ent0,
   input  logic                  i_push1,
   input  btb_ent_t              i_ent1,
   input  logic                  i_pop,
   output logic [$clog2(QDEP):0] o_occ,
   output btb_ent_t              o_head,
   output logic [1:0]            o_drop
);
   localparam int PW = $clog2(QDEP);

   btb_ent_t      r_mem [QDEP];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [PW:0]   r_occ;
   logic [PW:0]   w_free;
   logic [1:0]    w_req;
   logic [1:0]    w_acc;
   logic          w_pop;

   assign w_pop  = i_pop && (r_occ != '0);
   assign w_free = (PW+1)'(QDEP) - r_occ + (PW+1)'(w_pop);
   assign w_req  = {1'b0, i_push0} + {1'b0, i_push1};
   // When short of room free is 0 or 1; the first slot goes to the older commit.
   assign w_acc  = (w_free >= (PW+1)'(w_req)) ? w_req : w_free[1:0];
   assign o_drop = w_req - w_acc;
   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_occ <= '0;
      end else begin
         r_wp  <= r_wp + PW'(w_acc);
         r_rp  <= r_rp + PW'(w_pop);
         r_occ <= r_occ - (PW+1)'(w_pop) + (PW+1)'(w_acc);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && (w_acc != 2'd0)) r_mem[r_wp] <= i_push0 ? i_ent0 : i_ent1;
      if (!rst && (w_acc == 2'd2)) r_mem[r_wp + PW'(1)] <= i_ent1;
   end
endmodule

// File: rtl/ft64_btb_update.sv
// BTB writer: invalidates every entry after reset, then drains filtered
// commit-port branch outcomes to the BTB write port at one write per cycle.
module ft64_btb_update
   import ft64_btb_pkg::*;
#(
   parameter int            AMSB  = BTB_AMSB,
   parameter logic [AMSB:0] RSTPC = BTB_RSTPC,
   parameter int            QDEP  = 8,
   parameter int            IDXW  = BTB_IDXW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cmt0_v,
   input  logic [AMSB:0] cmt0_pc,
   input  logic [AMSB:0] cmt0_tgt,
   input  logic          cmt0_takb,
   input  logic          cmt0_bhit,
   input  logic          cmt1_v,
   input  logic [AMSB:0] cmt1_pc,
   input  logic [AMSB:0] cmt1_tgt,
   input  logic          cmt1_takb,
   input  logic          cmt1_bhit,
   output logic          rdy,
   output logic          wr,
   output logic [AMSB:0] wadr,
   output logic [AMSB:0] wdat,
   output logic          valid,
   output logic          busy,
   output logic [15:0]   drops
);
   localparam int QW = $clog2(QDEP);

   upd_state_t    r_state;
   upd_state_t    w_state_nxt;
   logic [IDXW-1:0] r_idx;
   logic          r_wr;
   logic          r_valid;
   logic          r_busy;
   logic [AMSB:0] r_wadr;
   logic [AMSB:0] r_wdat;
   logic [15:0]   r_drops;

   logic          w_run;
   logic          w_last;
   logic          w_pop;
   logic          w_push0;
   logic          w_push1;
   btb_ent_t      w_ent0;
   btb_ent_t      w_ent1;
   btb_ent_t      w_head;
   logic [QW:0]   w_occ;
   logic [1:0]    w_qdrop;
   logic [1:0]    w_sdrop;

   assign w_run   = (r_state == RUN);
   assign w_last  = (r_idx == '1);
   assign w_pop   = w_run && (w_occ != '0);
   assign w_push0 = w_run && cmt0_v && (cmt0_takb || cmt0_bhit);
   assign w_push1 = w_run && cmt1_v && (cmt1_takb || cmt1_bhit);
   // A not-taken branch that hit the BTB rewrites its slot as invalid; target unused.
   assign w_ent0  = {cmt0_takb, cmt0_pc, (cmt0_takb ? cmt0_tgt : cmt0_pc)};
   assign w_ent1  = {cmt1_takb, cmt1_pc, (cmt1_takb ? cmt1_tgt : cmt1_pc)};
   assign w_sdrop = {1'b0, cmt0_v} + {1'b0, cmt1_v};

   ft64_btb_updq #(.QDEP(QDEP)) u_q (
      .clk     (clk),
      .rst     (rst),
      .i_push0 (w_push0),
      .i_ent0  (w_ent0),
      .i_push1 (w_push1),
      .i_ent1  (w_ent1),
      .i_pop   (w_pop),
      .o_occ   (w_occ),
      .o_head  (w_head),
      .o_drop  (w_qdrop)
   );

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == SWEEP) && w_last) w_state_nxt = RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= SWEEP;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_wr    <= 1'b0;
         r_wadr  <= '0;
         r_wdat  <= RSTPC;
         r_valid <= 1'b0;
         r_busy  <= 1'b1;
         r_drops <= '0;
      end else if (!w_run) begin
         r_wr    <= 1'b1;
         r_wadr  <= (AMSB+1)'({r_idx, 2'b00});
         r_wdat  <= RSTPC;
         r_valid <= 1'b0;
         r_idx   <= r_idx + IDXW'(1);
         r_busy  <= !w_last;
         r_drops <= sat_add16(r_drops, w_sdrop);
      end else begin
         r_wr <= w_pop;
         if (w_pop) begin
            r_wadr  <= w_head.pc;
            r_wdat  <= w_head.tgt;
            r_valid <= w_head.valid;
         end
         r_drops <= sat_add16(r_drops, w_qdrop);
      end
   end

   // Derived only from registered state, so no input-to-rdy path.
   assign rdy   = w_run && (((QW+1)'(QDEP) - w_occ) >= (QW+1)'(2));
   assign wr    = r_wr;
   assign wadr  = r_wadr;
   assign wdat  = r_wdat;
   assign valid = r_valid;
   assign busy  = r_busy;
   assign drops = r_drops;
endmodule

// File: tb/tb_ft64_btb_update.sv
// Scoreboard bench for ft64_btb_update: a queue-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_ft64_btb_update;
   localparam logic [31:0] RPC  = 32'hFFFC0100;
   localparam int          NENT = 1024;
   localparam int          QD   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmt0_v = 1'b0, cmt0_takb = 1'b0, cmt0_bhit = 1'b0;
   logic [31:0] cmt0_pc = '0, cmt0_tgt = '0;
   logic        cmt1_v = 1'b0, cmt1_takb = 1'b0, cmt1_bhit = 1'b0;
   logic [31:0] cmt1_pc = '0, cmt1_tgt = '0;
   logic        rdy, wr, valid, busy;
   logic [31:0] wadr, wdat;
   logic [15:0] drops;

   always #5 clk = ~clk;

   ft64_btb_update dut (
      .clk(clk), .rst(rst),
      .cmt0_v(cmt0_v), .cmt0_pc(cmt0_pc), .cmt0_tgt(cmt0_tgt),
      .cmt0_takb(cmt0_takb), .cmt0_bhit(cmt0_bhit),
      .cmt1_v(cmt1_v), .cmt1_pc(cmt1_pc), .cmt1_tgt(cmt1_tgt),
      .cmt1_takb(cmt1_takb), .cmt1_bhit(cmt1_bhit),
      .rdy(rdy), .wr(wr), .wadr(wadr), .wdat(wdat), .valid(valid),
      .busy(busy), .drops(drops)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        v;
   } ment_t;

   typedef struct {
      logic        wr;
      logic        chk;
      logic        vld;
      logic        busy;
      logic        rdy;
      logic [31:0] adr;
      logic [31:0] dat;
      int          drops;
   } exp_t;

   ment_t mq[$];
   exp_t  sb[$];
   bit    m_run = 1'b0;
   int    m_idx = 0;
   int    m_drops = 0;
   int    total = 0;
   int    bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   task automatic offer(input bit v, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit tk, input bit bh);
      ment_t m;
      if (v && (tk || bh)) begin
         m.pc = pc; m.tgt = tk ? tgt : pc; m.v = tk;
         if (mq.size() < QD) mq.push_back(m);
         else m_drops = sat(m_drops + 1);
      end
   endtask

   // Predict the outputs after the coming clock edge from the driven inputs.
   task automatic model_step();
      exp_t  e;
      ment_t h;
      e = '{default: '0};
      if (rst) begin
         e.chk = 1'b1; e.adr = '0; e.dat = RPC; e.busy = 1'b1;
         m_run = 1'b0; m_idx = 0; m_drops = 0; mq.delete();
      end else if (!m_run) begin
         e.wr = 1'b1; e.chk = 1'b1; e.adr = 32'(m_idx * 4); e.dat = RPC;
         m_drops = sat(m_drops + int'(cmt0_v) + int'(cmt1_v));
         if (m_idx == NENT - 1) m_run = 1'b1;
         m_idx++;
         e.busy = !m_run; e.rdy = m_run;
      end else begin
         if (mq.size() > 0) begin
            h = mq.pop_front();
            e.wr = 1'b1; e.chk = 1'b1; e.adr = h.pc; e.dat = h.tgt; e.vld = h.v;
         end
         offer(cmt0_v, cmt0_pc, cmt0_tgt, cmt0_takb, cmt0_bhit);
         offer(cmt1_v, cmt1_pc, cmt1_tgt, cmt1_takb, cmt1_bhit);
         e.rdy = ((QD - mq.size()) >= 2);
      end
      e.drops = m_drops;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("wr", 32'(wr), 32'(e.wr));
         if (e.chk) begin
            check("wadr", wadr, e.adr);
            check("wdat", wdat, e.dat);
            check("valid", 32'(valid), 32'(e.vld));
         end
         check("busy", 32'(busy), 32'(e.busy));
         check("rdy", 32'(rdy), 32'(e.rdy));
         check("drops", 32'(drops), 32'(e.drops));
      end
   end

   task automatic drive(input bit r,
                        input bit v0, input logic [31:0] p0, input logic [31:0] t0,
                        input bit k0, input bit b0,
                        input bit v1, input logic [31:0] p1, input logic [31:0] t1,
                        input bit k1, input bit b1);
      @(negedge clk);
      #1;
      rst = r;
      cmt0_v = v0; cmt0_pc = p0; cmt0_tgt = t0; cmt0_takb = k0; cmt0_bhit = b0;
      cmt1_v = v1; cmt1_pc = p1; cmt1_tgt = t1; cmt1_takb = k1; cmt1_bhit = b1;
      model_step();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic rnd(input bit r);
      bit v0, v1, k0, k1, b0, b1;
      logic [31:0] p0, p1, t0, t1;
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 6);
      k0 = 1'($urandom); k1 = 1'($urandom); b0 = 1'($urandom); b1 = 1'($urandom);
      p0 = $urandom & 32'h0000FFFC; p1 = $urandom & 32'h0000FFFC;
      t0 = $urandom & 32'hFFFFFFFC; t1 = $urandom & 32'hFFFFFFFC;
      drive(r, v0, p0, t0, k0, b0, v1, p1, t1, k1, b1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      // full sweep with one stray commit
      for (int c = 0; c < NENT; c++) begin
         if (c == 5) drive(1'b0, 1'b1, 32'h3000, 32'h3100, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
         else idle(1);
      end
      idle(2);
      drive(1'b0, 1'b1, 32'h1000, 32'h2040, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      idle(3);
      drive(1'b0, 1'b1, 32'h1004, 32'h5554, 1'b0, 1'b1, 1'b1, 32'h1008, 32'h6664, 1'b0, 1'b0);
      idle(3);
      for (int k = 0; k < 10; k++)
         drive(1'b0, 1'b1, 32'h100 + 32'(8 * k), $urandom & 32'hFFFFFFFC, 1'b1, 1'b0,
               1'b1, 32'h104 + 32'(8 * k), $urandom & 32'hFFFFFFFC, 1'b1, 1'b0);
      idle(12);
      drive(1'b0, 1'b1, 32'h2220, 32'hAAA0, 1'b1, 1'b0, 1'b1, 32'h2220, 32'hBBB0, 1'b1, 1'b0);
      idle(3);
      repeat (400) rnd(1'b0);
      // reset mid-run, then again partway through the sweep
      rnd(1'b1);
      for (int c = 0; c < 2000 && m_idx != 300; c++) idle(1);
      rnd(1'b1);
      repeat (NENT) rnd(1'b0);
      repeat (300) rnd(1'b0);
      idle(12);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ft64_btb_update.md
Name: ft64_btb_update

Overview:
- Writer side of the FT64 branch target buffer. Collects resolved branch outcomes from the two commit ports and queues them, then drives the BTB write port (wr/wadr/wdat/valid) at one write per cycle.
- After reset it sweeps every BTB entry to invalid before accepting commits.
- Sits between the commit stage and the BTB write port. It runs on the BTB write clock.

Parameters:
- AMSB, 31, MSB of address/target buses.
- RSTPC, 32'hFFFC0100, target value written during the invalidate sweep.
- QDEP, 8, update queue depth (power of two, >=4).
- IDXW, 10, BTB index width (1<<IDXW entries; index = pc[IDXW+1:2]).

Ports:
- clk  in  1  single clock, also the BTB wclk.
- rst  in  1  reset: synchronous, active-high.
- cmt0_v  in  1  commit port 0 retires a resolved branch.
- cmt0_pc  in  AMSB+1  branch PC.
- cmt0_tgt  in  AMSB+1  resolved target.
- cmt0_takb  in  1  branch was taken.
- cmt0_bhit  in  1  BTB supplied a prediction for this branch at fetch.
- cmt1_v, cmt1_pc, cmt1_tgt, cmt1_takb, cmt1_bhit  in  (as port 0)  commit port 1; younger than port 0.
- rdy  out  1  at least 2 free queue slots and not sweeping.
- wr  out  1  BTB write strobe.
- wadr  out  AMSB+1  BTB write address/tag.
- wdat  out  AMSB+1  BTB write target.
- valid  out  1  BTB entry valid bit.
- busy  out  1  sweep in progress.
- drops  out  16  saturating count of commits lost to a full queue or the sweep.

Behaviour:
- Reset values: wr=0, wadr=0, wdat=RSTPC, valid=0, busy=1, rdy=0, drops=0; queue emptied; FSM=SWEEP with index counter=0.
- FSM state SWEEP:
  - Each cycle drive wr=1, wadr={0.., idx, 2'b00}, wdat=RSTPC, valid=0, then idx++.
  - After writing idx=(1<<IDXW)-1, go to RUN; busy falls in that same cycle's register update.
  - A sweep takes exactly 1<<IDXW write cycles.
  - Commits arriving during SWEEP are discarded; each valid one increments drops.
- FSM state RUN:
  - rdy = (free slots >= 2), registered from the current occupancy.
- Push filter, per port with cmtN_v=1:
  - takb=1: enqueue {pc, tgt, valid=1}.
  - takb=0 and bhit=1: enqueue {pc, tgt=don't care (drive pc), valid=0} to invalidate the stale entry.
  - takb=0 and bhit=0: no enqueue and no drop.
- Push ordering: up to 2 pushes per cycle; port 0 goes in before port 1.
- Pushes that do not fit the free slots (counted after any same-cycle pop) are dropped. If only one slot is free, port 0 is kept and port 1 is dropped. drops increments by 1 or 2 and saturates at 16'hFFFF.
- Pop:
  - In RUN, when the queue is non-empty, pop the head and register it onto the outputs: wr=1, wadr=pc, wdat=tgt, valid=entry.valid.
  - Otherwise wr=0 and the other outputs hold their values.
  - Latency: a push into an empty queue at edge t appears as wr=1 after edge t+1. There is no combinational bypass.
- Same PC on both ports in one cycle: both are enqueued and written in order, so port 1 wins in the BTB.
- Back-to-back writes to the same index are not coalesced.
- Occupancy counter range is 0..QDEP. Pointers wrap modulo QDEP. Simultaneous push-2 and pop-1 nets +1.
- Reset asserted mid-SWEEP or mid-RUN: queue cleared, drops cleared, sweep restarts at idx=0 on the next cycle.

Decomposition:
- Shared package ft64_btb_pkg:
  - entry typedef {valid, pc[AMSB:0], tgt[AMSB:0]};
  - IDXW;
  - RSTPC;
  - FSM state enum {SWEEP, RUN}.
- Sub-module ft64_btb_updq: a QDEP-entry FIFO with 2 push ports and 1 pop port. Outputs: occupancy, head entry, dropped-count-per-cycle (0..2). The top level holds the FSM, the push filter, the output registers and the drops counter.

Test Plan:
- Reset release, no commits -> 1024 consecutive cycles with wr=1, wadr stepping 0x0,0x4,...,0xFFC, valid=0, wdat=FFFC0100. Then busy=0, rdy=1 and wr=0 the next cycle.
- RUN, cmt0 {v=1, pc=0x1000, tgt=0x2040, takb=1} -> one cycle later wr=1, wadr=0x1000, wdat=0x2040, valid=1; then wr=0.
- cmt0 {pc=0x1004, takb=0, bhit=1} and cmt1 {pc=0x1008, takb=0, bhit=0} same cycle -> exactly one write, wadr=0x1004 with valid=0; drops unchanged.
- Both ports taken every cycle for 10 cycles (pcs 0x100..0x14C step 4) -> rdy falls once occupancy >6. Writes emerge in port0/port1 order at 1 per cycle, and drops equals the number of pushes that exceeded free slots (model-checked).
- Commit during sweep at cycle 5 -> no extra write; drops=1.
- Assert rst at sweep idx=300, hold 1 cycle -> next write wadr=0x0. drops=0 and the queue is empty.
